uart_duty_rx: RTL and testbench

//  UART 8N1 receiver that supplies the 8-bit duty-cycle word to the PWM stage.

---
 rtl/uart_duty_pkg.sv | 22 ++
 rtl/baud_tick_gen.sv | 46 ++++
 rtl/uart_duty_rx.sv | 154 +++++++++++++++
 tb/tb_uart_duty_rx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_duty_pkg.sv
// Shared types and helpers for the duty-cycle UART receiver and its baud tick generator.
package uart_duty_pkg;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_e;

  localparam int unsigned OVS_DEFAULT = 16;

  // Clock cycles per oversampling tick. Integer division truncates.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned ovs);
    return clk_hz / (baud * ovs);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: one-clock tick every DIV clocks, clearable to re-phase.
module baud_tick_gen
  import uart_duty_pkg::*;
#(
  parameter int unsigned CLK_HZ = 10_000_000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned OVS    = OVS_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD, OVS);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Divider next state: wrap at DIV-1 and emit a tick, or restart on clear.
  always_comb begin
    cnt_d  = cnt_q + DIV_W'(1);
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == DIV_W'(DIV - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Divider and tick registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_duty_rx.sv
// UART 8N1 receiver with 16x oversampling; latches each good byte as the PWM duty word.
module uart_duty_rx
  import uart_duty_pkg::*;
#(
  parameter int unsigned CLK_HZ = 10_000_000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned OVS    = OVS_DEFAULT,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_i,
  output logic [DATA_W-1:0] duty_o,
  output logic              duty_valid_o,
  output logic              frame_err_o,
  output logic              busy_o
);

  localparam int unsigned TICK_W = $clog2(OVS);
  localparam int unsigned BIT_W  = $clog2(DATA_W + 1);
  localparam int unsigned HALF   = OVS / 2;

  logic              rx_meta_q, rx_s_q, rx_prev_q;
  logic              fall_edge;
  logic              tick;
  logic              tick_clr;
  rx_state_e         state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] duty_q, duty_d;
  logic              duty_valid_q, duty_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q;

  baud_tick_gen #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .OVS   (OVS)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall_edge = rx_prev_q & ~rx_s_q;

  // Frame FSM: next state, sample counters, shift register and output pulses.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    tick_clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall_edge) begin
          state_d    = START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          tick_clr   = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == TICK_W'(HALF - 1)) begin
            tick_cnt_d = '0;
            state_d    = rx_s_q ? IDLE : DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == TICK_W'(OVS - 1)) begin
            shift_d   = {rx_s_q, shift_q[DATA_W-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
              state_d = STOP;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == TICK_W'(OVS - 1)) begin
            if (rx_s_q) begin
              duty_d       = shift_q;
              duty_valid_d = 1'b1;
              state_d      = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_HI;
            end
          end
        end
      end
      WAIT_HI: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, datapath and output registers; reset aborts any frame and clears the duty word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  assign duty_o       = duty_q;
  assign duty_valid_o = duty_valid_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_duty_rx.sv
// Self-checking bench for uart_duty_rx: table-driven frames, corner sequences, random frames.
`timescale 1ns/1ps
module tb_uart_duty_rx;

  // 2 MHz clock keeps simulated frames short; DIV = 2e6/(9600*16) = 13 (truncated from 13.02).
  localparam int unsigned CLK_HZ = 2_000_000;
  localparam int unsigned BAUD   = 9600;
  localparam real         CLK_NS = 1.0e9 / real'(CLK_HZ);
  localparam real         BIT_NS = 1.0e9 / real'(BAUD);

  logic       clk;
  logic       rst;
  logic       rx_i;
  logic [7:0] duty_o;
  logic       duty_valid_o;
  logic       frame_err_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  uart_duty_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .OVS   (16),
    .DATA_W(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_i),
    .duty_o      (duty_o),
    .duty_valid_o(duty_valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #(CLK_NS / 2.0) clk = ~clk;

  // Output monitor, sampled on the falling edge.
  int         n_valid = 0;
  int         n_err = 0;
  int         both_seen = 0;
  int         bad_change = 0;
  int         busy_cnt = 0;
  logic [7:0] obs_last = 8'h00;
  logic [7:0] duty_prev = 8'h00;

  always @(negedge clk) begin
    if (duty_valid_o) begin
      n_valid++;
      obs_last = duty_o;
    end
    if (frame_err_o) n_err++;
    if (duty_valid_o && frame_err_o) both_seen++;
    if (busy_o) busy_cnt++;
    if (!rst && !duty_valid_o && duty_o !== duty_prev) bad_change++;
    duty_prev = duty_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one 8N1 frame, LSB first; rx is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input real bit_ns);
    rx_i = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      #(bit_ns);
    end
    rx_i = stop_bit;
    #(bit_ns);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop_ok;
    int unsigned gap_bits;
    logic [7:0]  exp_duty;
    int          exp_valid;
    int          exp_err;
  } vec_t;

  vec_t       vecs[6];
  int         v0, e0, b0;
  logic [7:0] model_duty;
  logic [7:0] rdata;
  logic       rstop;
  int         rgap, rhold, rppm;
  real        rbit;

  initial begin
    // Frames: 0x80; back-to-back 0x00/0xFF/0xA5; 0x3C with bad stop; 0x11 after recovery.
    vecs[0] = '{8'h80, 1'b1, 1, 8'h80, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 0, 8'h00, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 0, 8'hFF, 1, 0};
    vecs[3] = '{8'hA5, 1'b1, 1, 8'hA5, 1, 0};
    vecs[4] = '{8'h3C, 1'b0, 1, 8'hA5, 0, 1};
    vecs[5] = '{8'h11, 1'b1, 1, 8'h11, 1, 0};

    rst  = 1'b1;
    rx_i = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_duty", 32'(duty_o), 32'h00);
    check("reset_busy", 32'(busy_o), 32'h0);
    check("reset_valid", 32'(duty_valid_o), 32'h0);
    check("reset_ferr", 32'(frame_err_o), 32'h0);
    rst = 1'b0;

    // Idle line for 2 ms: nothing happens.
    v0 = n_valid; e0 = n_err; b0 = busy_cnt;
    #(2.0e6);
    @(negedge clk);
    check("idle_valid_cnt", 32'(n_valid - v0), 32'd0);
    check("idle_err_cnt", 32'(n_err - e0), 32'd0);
    check("idle_busy_cnt", 32'(busy_cnt - b0), 32'd0);
    check("idle_duty", 32'(duty_o), 32'h00);

    // Table-driven frames.
    for (int k = 0; k < 6; k++) begin
      v0 = n_valid; e0 = n_err;
      send_frame(vecs[k].data, vecs[k].stop_ok, BIT_NS);
      if (!vecs[k].stop_ok) begin
        #(BIT_NS);
        @(negedge clk);
        check($sformatf("vec%0d_waithi_busy", k), 32'(busy_o), 32'h1);
        #(2.0 * BIT_NS);
        rx_i = 1'b1;
      end
      #(real'(vecs[k].gap_bits) * BIT_NS);
      check($sformatf("vec%0d_valid_cnt", k), 32'(n_valid - v0), 32'(vecs[k].exp_valid));
      check($sformatf("vec%0d_err_cnt", k), 32'(n_err - e0), 32'(vecs[k].exp_err));
      check($sformatf("vec%0d_obs_byte", k), 32'(obs_last), 32'(vecs[k].exp_duty));
      if (vecs[k].gap_bits > 0) begin
        @(negedge clk);
        check($sformatf("vec%0d_duty", k), 32'(duty_o), 32'(vecs[k].exp_duty));
        check($sformatf("vec%0d_busy_idle", k), 32'(busy_o), 32'h0);
      end
    end

    // Short low glitch (3 ticks) on an idle line is rejected at the start-bit check.
    v0 = n_valid; e0 = n_err;
    @(negedge clk);
    rx_i = 1'b0;
    repeat (6) @(negedge clk);
    check("glitch_busy", 32'(busy_o), 32'h1);
    repeat (3 * 13 - 6) @(negedge clk);
    rx_i = 1'b1;
    #(BIT_NS);
    @(negedge clk);
    check("glitch_busy_after", 32'(busy_o), 32'h0);
    check("glitch_valid_cnt", 32'(n_valid - v0), 32'd0);
    check("glitch_err_cnt", 32'(n_err - e0), 32'd0);
    check("glitch_duty", 32'(duty_o), 32'h11);

    // Reset in the middle of the data bits of 0x55.
    v0 = n_valid;
    rx_i = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 3; i++) begin
      rx_i = i[0] ? 1'b0 : 1'b1;
      #(BIT_NS);
    end
    #(BIT_NS / 2.0);
    rst = 1'b1;
    #1;
    check("midrst_duty", 32'(duty_o), 32'h00);
    check("midrst_busy", 32'(busy_o), 32'h0);
    rx_i = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #(2.0 * BIT_NS);
    check("midrst_no_valid", 32'(n_valid - v0), 32'd0);
    send_frame(8'h66, 1'b1, BIT_NS);
    #(BIT_NS);
    @(negedge clk);
    check("after_rst_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("after_rst_duty", 32'(duty_o), 32'h66);

    // Baud mismatch of +2% and -2%.
    v0 = n_valid;
    send_frame(8'h80, 1'b1, BIT_NS * 0.98);
    #(BIT_NS);
    @(negedge clk);
    check("fast_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("fast_duty", 32'(duty_o), 32'h80);
    v0 = n_valid;
    send_frame(8'h81, 1'b1, BIT_NS * 1.02);
    #(BIT_NS);
    @(negedge clk);
    check("slow_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("slow_duty", 32'(duty_o), 32'h81);

    // Random frames against a reference: duty is the last byte whose stop bit was high.
    model_duty = 8'h81;
    for (int n = 0; n < 6; n++) begin
      rdata = 8'($urandom);
      rstop = ($urandom_range(3) != 0);
      rgap  = int'($urandom_range(2));
      rhold = 1 + int'($urandom_range(2));
      rppm  = int'($urandom_range(30)) - 15;
      rbit  = BIT_NS * (1.0 + real'(rppm) / 1000.0);
      v0 = n_valid; e0 = n_err;
      send_frame(rdata, rstop, rbit);
      if (!rstop) begin
        #(real'(rhold) * rbit);
        rx_i = 1'b1;
        #(rbit);
      end else begin
        model_duty = rdata;
      end
      #(real'(rgap) * rbit);
      check($sformatf("rnd%0d_valid_cnt", n), 32'(n_valid - v0), 32'(rstop ? 1 : 0));
      check($sformatf("rnd%0d_err_cnt", n), 32'(n_err - e0), 32'(rstop ? 0 : 1));
      check($sformatf("rnd%0d_duty", n), 32'(obs_last), 32'(model_duty));
    end
    #(BIT_NS);
    @(negedge clk);
    check("final_duty", 32'(duty_o), 32'(model_duty));
    check("valid_err_overlap", 32'(both_seen), 32'd0);
    check("duty_change_without_valid", 32'(bad_change), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
